// File: rtl/cv32e40p_obi_mem_responder.sv
// OBI memory-side responder: word reads / byte-enabled writes on internal storage,
// in-order responses after a fixed RESP_LATENCY, at most MAX_OUTSTANDING in flight.
module cv32e40p_obi_mem_responder #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned MEM_DEPTH_WORDS = 1024,
    parameter int unsigned RESP_LATENCY    = 1,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     req_i,
    output logic                                     gnt_o,
    input  logic [ADDR_WIDTH-1:0]                    addr_i,
    input  logic                                     we_i,
    input  logic [3:0]                               be_i,
    input  logic [31:0]                              wdata_i,
    output logic                                     rvalid_o,
    output logic [31:0]                              rdata_o,
    output logic                                     err_o,
    input  logic                                     gnt_stall_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding_o
);

    localparam int unsigned IW = ADDR_WIDTH - 2;
    localparam int unsigned MW = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    logic [31:0]           mem [MEM_DEPTH_WORDS];
    logic [IW-1:0]         word_idx;
    logic [MW-1:0]         mem_idx;
    logic                  in_range;
    logic                  acc;
    logic [OW-1:0]         cnt;
    logic [RESP_LATENCY:1] vld_pipe;
    rsp_t                  rsp_pipe [1:RESP_LATENCY];
    rsp_t                  rsp_in;
    logic                  unused_addr_lsb;

    assign word_idx        = addr_i[ADDR_WIDTH-1:2];
    assign mem_idx         = word_idx[MW-1:0];
    assign in_range        = word_idx < IW'(MEM_DEPTH_WORDS);
    assign unused_addr_lsb = ^addr_i[1:0];

    // Grant depends only on the current count, never on rvalid_o.
    assign gnt_o = req_i & ~gnt_stall_i & (cnt < OW'(MAX_OUTSTANDING));
    assign acc   = req_i & gnt_o;

    // Reads sample the array before this edge's write, so a read accepted the
    // cycle after a write to the same word sees the updated contents.
    always_comb begin
        rsp_in = '0;
        if (acc) begin
            if (!in_range)
                rsp_in.err = 1'b1;
            else if (!we_i)
                rsp_in.rdata = mem[mem_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (acc && we_i && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b])
                    mem[mem_idx][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    // Non-valid slots carry zeros so rdata_o/err_o idle at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            for (int i = 1; i <= int'(RESP_LATENCY); i++)
                rsp_pipe[i] <= '0;
        end else begin
            vld_pipe[1] <= acc;
            rsp_pipe[1] <= rsp_in;
            for (int i = 2; i <= int'(RESP_LATENCY); i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                rsp_pipe[i] <= rsp_pipe[i-1];
            end
        end
    end

    assign rvalid_o = vld_pipe[RESP_LATENCY];
    assign rdata_o  = rsp_pipe[RESP_LATENCY].rdata;
    assign err_o    = rsp_pipe[RESP_LATENCY].err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            case ({acc, rvalid_o})
                2'b10:   cnt <= cnt + OW'(1);
                2'b01:   cnt <= cnt - OW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign outstanding_o = cnt;

endmodule

// File: tb/tb_cv32e40p_obi_mem_responder.sv
// Bench for cv32e40p_obi_mem_responder: vector table plus hand-written corner
// sequences; a negedge monitor scoreboards responses, grant and outstanding count.
module tb_cv32e40p_obi_mem_responder;

    localparam int unsigned LAT  = 3;
    localparam int unsigned MAXO = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_i = 1'b0;
    logic        gnt_o;
    logic [31:0] addr_i = '0;
    logic        we_i = 1'b0;
    logic [3:0]  be_i = '0;
    logic [31:0] wdata_i = '0;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        gnt_stall_i = 1'b0;
    logic [1:0]  outstanding_o;

    cv32e40p_obi_mem_responder #(
        .ADDR_WIDTH(32), .MEM_DEPTH_WORDS(1024),
        .RESP_LATENCY(LAT), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .gnt_o(gnt_o),
        .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
        .gnt_stall_i(gnt_stall_i), .outstanding_o(outstanding_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        q[$];
    vec_t        vt[17];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          max_out = 0;
    logic        acc_seen = 1'b0;
    logic [31:0] cur_rdata = '0;
    logic        cur_err = 1'b0;
    int          sz;
    logic        exp_rv, exp_g;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, want, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: expected grant from the model's own in-flight count,
    // responses due exactly LAT cycles after the accepting cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            sz     = q.size();
            exp_rv = (sz > 0) && (q[0].due == cyc);
            chk("rvalid", 32'(rvalid_o), 32'(exp_rv));
            if (exp_rv) begin
                chk("rdata", rdata_o, q[0].rdata);
                chk("err", 32'(err_o), 32'(q[0].err));
                void'(q.pop_front());
            end else begin
                chk("rdata_idle", rdata_o, 32'h0);
                chk("err_idle", 32'(err_o), 32'h0);
            end
            chk("outstanding", 32'(outstanding_o), 32'(sz));
            if (int'(outstanding_o) > max_out) max_out = int'(outstanding_o);
            exp_g = req_i & ~gnt_stall_i & (sz < int'(MAXO));
            chk("gnt", 32'(gnt_o), 32'(exp_g));
            acc_seen = exp_g;
            if (exp_g) q.push_back('{cyc + int'(LAT), cur_rdata, cur_err});
        end else begin
            acc_seen = 1'b0;
        end
    end

    // Called at a posedge; returns at the posedge that closes the accepting cycle.
    task automatic issue(input vec_t v);
        int n = 0;
        #1;
        gnt_stall_i = 1'b0;
        req_i = 1'b1; addr_i = v.addr; we_i = v.we; be_i = v.be; wdata_i = v.wdata;
        cur_rdata = v.exp_rdata; cur_err = v.exp_err;
        do begin
            @(posedge clk);
            n++;
        end while (!acc_seen && n < 40);
        if (!acc_seen) begin
            errors++;
            $display("FAIL grant_timeout actual=no_grant expected=grant addr=%h", v.addr);
        end
    endtask

    task automatic idle(input int n);
        #1;
        req_i = 1'b0; gnt_stall_i = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        vt[0]  = '{32'h10,   1, 4'hF, 32'hDEADBEEF, 32'h0,        0};
        vt[1]  = '{32'h10,   0, 4'h0, 32'h0,        32'hDEADBEEF, 0};
        vt[2]  = '{32'h20,   1, 4'hF, 32'h11223344, 32'h0,        0};
        vt[3]  = '{32'h20,   1, 4'h5, 32'hAABBCCDD, 32'h0,        0};
        vt[4]  = '{32'h20,   0, 4'hF, 32'h0,        32'h11BB33DD, 0};
        vt[5]  = '{32'h1000, 0, 4'hF, 32'h0,        32'h0,        1};
        vt[6]  = '{32'h0,    1, 4'hF, 32'h01020304, 32'h0,        0};
        vt[7]  = '{32'h1000, 1, 4'hF, 32'hFFFFFFFF, 32'h0,        1};
        vt[8]  = '{32'h0,    0, 4'hF, 32'h0,        32'h01020304, 0};
        vt[9]  = '{32'h13,   0, 4'h0, 32'h0,        32'hDEADBEEF, 0};
        vt[10] = '{32'h24,   1, 4'hF, 32'h0,        32'h0,        0};
        vt[11] = '{32'h24,   1, 4'h8, 32'hA5A5A5A5, 32'h0,        0};
        vt[12] = '{32'h24,   0, 4'hF, 32'h0,        32'hA5000000, 0};
        vt[13] = '{32'hFFC,  1, 4'hF, 32'hCAFEF00D, 32'h0,        0};
        vt[14] = '{32'hFFC,  0, 4'hF, 32'h0,        32'hCAFEF00D, 0};
        vt[15] = '{32'h8,    1, 4'hF, 32'h55AA55AA, 32'h0,        0};
        vt[16] = '{32'h1004, 0, 4'hF, 32'h0,        32'h0,        1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rvalid", 32'(rvalid_o), 32'h0);
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        chk("rst_outstanding", 32'(outstanding_o), 32'h0);
        chk("rst_gnt", 32'(gnt_o), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);

        // Table stream with req held high: exercises full/throttle and RAW hazard.
        for (int i = 0; i < 17; i++) issue(vt[i]);
        idle(8);
        chk("max_outstanding_reached", 32'(max_out), 32'(MAXO));

        // Address phase wanders while stalled; only the released phase counts.
        #1;
        req_i = 1'b1; gnt_stall_i = 1'b1; we_i = 1'b1; be_i = 4'hF; wdata_i = 32'hBAD0BAD0;
        addr_i = 32'h0; @(posedge clk); #1;
        addr_i = 32'h4; @(posedge clk); #1;
        addr_i = 32'h0; @(posedge clk);
        issue('{32'h8, 0, 4'hF, 32'h0, 32'h55AA55AA, 0});
        issue('{32'h0, 0, 4'hF, 32'h0, 32'h01020304, 0});
        idle(8);

        // Reset with two reads in flight: nothing may emerge afterwards.
        @(posedge clk);
        issue('{32'h10, 0, 4'hF, 32'h0, 32'hDEADBEEF, 0});
        issue('{32'h20, 0, 4'hF, 32'h0, 32'h11BB33DD, 0});
        #1;
        req_i = 1'b0;
        chk("pre_rst_outstanding", 32'(outstanding_o), 32'h2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rvalid", 32'(rvalid_o), 32'h0);
        chk("mid_rst_outstanding", 32'(outstanding_o), 32'h0);
        chk("mid_rst_rdata", rdata_o, 32'h0);
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);

        // Storage survives reset.
        issue('{32'h10, 0, 4'hF, 32'h0, 32'hDEADBEEF, 0});
        idle(8);
        chk("drained", 32'(q.size()), 32'h0);
        chk("final_outstanding", 32'(outstanding_o), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
